clk_rst_seq: RTL and testbench

Synthesizable reset sequencer and multi-channel tick generator for the RISC-V top level and its simulation harness. It releases the system reset a fixed number of cycles after the external reset deasserts. It then produces divided-clock toggles and single-cycle strobes on `N_CH` channels, in free-run or single-step mode, for slow or manual clocking of peripherals and debug logic. It sits between the board clock/reset pins and `riscv_top` internals, replacing ad-hoc bench-side clock and reset waveforms.

---
 rtl/clk_rst_seq_pkg.sv | 18 +
 rtl/clk_rst_seq_rst_sync2.sv | 23 ++
 rtl/clk_rst_seq.sv | 114 +++++++++++
 tb/tb_clk_rst_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_seq_pkg.sv
// Shared types and parameter bounds for the reset sequencer / tick generator.
package clk_rst_seq_pkg;

    localparam int unsigned DIV_W_MIN      = 1;
    localparam int unsigned DIV_W_MAX      = 16;
    localparam int unsigned N_CH_MIN       = 1;
    localparam int unsigned N_CH_MAX       = 8;
    localparam int unsigned RST_CYCLES_MAX = 65535;
    localparam int unsigned HOLD_W         = 16;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_IDLE = 2'd1,
        S_RUN  = 2'd2,
        S_STEP = 2'd3
    } seq_state_e;

endpackage

// File: rtl/clk_rst_seq_rst_sync2.sv
// Two-flop reset synchronizer: asynchronous assertion, release after two edges.
module rst_sync2 (
    input  logic clk,
    input  logic rst_n,
    output logic rst_n_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= 1'b1;
            sync_q <= meta_q;
        end
    end

    assign rst_n_sync = sync_q;

endmodule

// File: rtl/clk_rst_seq.sv
// Reset sequencer: holds sys_rst_out after reset release, then generates
// divided tick toggles/strobes on N_CH channels in free-run or single-step mode.
module clk_rst_seq
    import clk_rst_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 25,
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned DIV_RESET  = 3,
    parameter int unsigned N_CH       = 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic             step_req,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_in,
    output logic             sys_rst_out,
    output logic [N_CH-1:0]  tick_out,
    output logic [N_CH-1:0]  tick_pulse,
    output logic             busy
);

    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RST_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_RESET_V = DIV_W'(DIV_RESET);

    seq_state_e        state;
    logic              rst_n_sync;
    logic              sys_rst_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_last;
    logic [N_CH-1:0]   presc_q;
    logic [N_CH-1:0]   toggle_mask;
    logic              tick_ev;

    rst_sync2 u_rst_sync (
        .clk        (clk_in),
        .rst_n      (rst_n),
        .rst_n_sync (rst_n_sync)
    );

    // A divide ratio of 0 behaves as 1, so its terminal count is also 0.
    assign div_last = (div_q == '0) ? '0 : div_q - DIV_W'(1);
    assign busy     = (state == S_RUN) || (state == S_STEP);
    assign tick_ev  = busy && (div_cnt == div_last);

    // Channel k toggles when all lower prescaler bits are set.
    always_comb begin
        toggle_mask    = '0;
        toggle_mask[0] = 1'b1;
        for (int unsigned k = 1; k < N_CH; k++) begin
            toggle_mask[k] = toggle_mask[k-1] & presc_q[k-1];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_HOLD;
            sys_rst_q  <= 1'b1;
            hold_cnt   <= '0;
            div_q      <= DIV_RESET_V;
            div_cnt    <= '0;
            presc_q    <= '0;
            tick_out   <= '0;
            tick_pulse <= '0;
        end else begin
            tick_pulse <= tick_ev ? toggle_mask : '0;
            if (tick_ev) begin
                tick_out <= tick_out ^ toggle_mask;
                presc_q  <= presc_q + N_CH'(1);
            end
            if (div_load) begin
                div_q <= div_in;
            end

            unique case (state)
                S_HOLD: begin
                    if (rst_n_sync) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state     <= S_IDLE;
                            sys_rst_q <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                S_IDLE: begin
                    div_cnt <= '0;
                    if (run_en) begin
                        state <= S_RUN;
                    end else if (step_req) begin
                        state <= S_STEP;
                    end
                end
                S_RUN, S_STEP: begin
                    // A reload restarts the count even when it coincides with a tick.
                    if (tick_ev || div_load) begin
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                    if (tick_ev && ((state == S_STEP) || !run_en)) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_HOLD;
            endcase
        end
    end

    assign sys_rst_out = sys_rst_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Scoreboard bench for clk_rst_seq: a behavioural model queues the expected
// outputs for every edge, and a negedge monitor compares them against the DUT.
module tb_clk_rst_seq;

    localparam int unsigned RST_CYCLES = 25;
    localparam int unsigned DIV_W      = 8;
    localparam int unsigned DIV_RESET  = 3;
    localparam int unsigned N_CH       = 2;

    logic             clk_in   = 1'b0;
    logic             rst_n    = 1'b0;
    logic             run_en   = 1'b0;
    logic             step_req = 1'b0;
    logic             div_load = 1'b0;
    logic [DIV_W-1:0] div_in   = '0;
    logic             sys_rst_out;
    logic [N_CH-1:0]  tick_out;
    logic [N_CH-1:0]  tick_pulse;
    logic             busy;

    clk_rst_seq #(
        .RST_CYCLES (RST_CYCLES),
        .DIV_W      (DIV_W),
        .DIV_RESET  (DIV_RESET),
        .N_CH       (N_CH)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .run_en      (run_en),
        .step_req    (step_req),
        .div_load    (div_load),
        .div_in      (div_in),
        .sys_rst_out (sys_rst_out),
        .tick_out    (tick_out),
        .tick_pulse  (tick_pulse),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic            sys_rst;
        logic [N_CH-1:0] tout;
        logic [N_CH-1:0] tpulse;
        logic            busy;
    } obs_t;

    typedef enum {M_HOLD, M_IDLE, M_RUN, M_STEP} mmode_e;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: edges since release, cycles since the period origin,
    // and the total tick count (tick_out[k] is bit k of that count).
    mmode_e          m_mode;
    int unsigned     m_rel;
    int unsigned     m_elapsed;
    int unsigned     m_ticks;
    int unsigned     m_div;
    logic [N_CH-1:0] m_pulse;
    int unsigned     m_tick_total = 0;
    int unsigned     dut_ticks    = 0;

    task automatic model_reset();
        m_mode    = M_HOLD;
        m_rel     = 0;
        m_elapsed = 0;
        m_ticks   = 0;
        m_div     = DIV_RESET;
        m_pulse   = '0;
    endtask

    task automatic model_edge();
        int unsigned d;
        logic        tick;
        mmode_e      nxt;
        m_pulse = '0;
        if (m_mode == M_HOLD) begin
            m_rel++;
            if (m_rel == RST_CYCLES + 2) m_mode = M_IDLE;
        end else begin
            d    = (m_div == 0) ? 1 : m_div;
            tick = 1'b0;
            nxt  = m_mode;
            case (m_mode)
                M_IDLE: begin
                    if (run_en) nxt = M_RUN;
                    else if (step_req) nxt = M_STEP;
                end
                default: begin
                    m_elapsed++;
                    if (m_elapsed == d) begin
                        tick      = 1'b1;
                        m_elapsed = 0;
                        if (m_mode == M_STEP || !run_en) nxt = M_IDLE;
                    end
                end
            endcase
            if (tick) begin
                m_pulse = N_CH'(m_ticks ^ (m_ticks + 1));
                m_ticks++;
                m_tick_total++;
            end
            if (div_load && m_mode != M_IDLE) m_elapsed = 0;
            if (nxt != m_mode) m_elapsed = 0;
            m_mode = nxt;
        end
        if (div_load) m_div = div_in;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.sys_rst = (m_mode == M_HOLD);
        o.tout    = N_CH'(m_ticks);
        o.tpulse  = m_pulse;
        o.busy    = (m_mode == M_RUN) || (m_mode == M_STEP);
        return o;
    endfunction

    always @(posedge clk_in) begin
        if (!rst_n) model_reset();
        else model_edge();
        exp_q.push_back(model_obs());
    end

    obs_t mon_exp;
    obs_t mon_act;

    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {sys_rst_out, tick_out, tick_pulse, busy};
            checks++;
            if (mon_act !== mon_exp) begin
                failures++;
                $display("FAIL cycle_obs t=%0t got sys_rst=%b tick_out=%b tick_pulse=%b busy=%b expected sys_rst=%b tick_out=%b tick_pulse=%b busy=%b",
                         $time, mon_act.sys_rst, mon_act.tout, mon_act.tpulse, mon_act.busy,
                         mon_exp.sys_rst, mon_exp.tout, mon_exp.tpulse, mon_exp.busy);
            end
            if (tick_pulse[0] === 1'b1) dut_ticks++;
        end
    end

    task automatic cyc(input int unsigned n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic pulse_step();
        step_req = 1'b1;
        cyc(1);
        step_req = 1'b0;
    endtask

    task automatic load(input logic [DIV_W-1:0] v);
        div_in   = v;
        div_load = 1'b1;
        cyc(1);
        div_load = 1'b0;
    endtask

    // Assert reset between edges and check outputs before any clock arrives.
    task automatic async_reset_check();
        logic [5:0] got;
        @(negedge clk_in);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        got = {sys_rst_out, tick_out, tick_pulse, busy};
        checks++;
        if (got !== {1'b1, {N_CH{1'b0}}, {N_CH{1'b0}}, 1'b0}) begin
            failures++;
            $display("FAIL async_reset t=%0t got sys_rst/tick_out/tick_pulse/busy=%b expected 1/0/0/0", $time, got);
        end
        cyc(3);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(32);

        // Free run at the reset divide ratio
        run_en = 1'b1;
        cyc(40);
        run_en = 1'b0;
        cyc(8);

        // Single step, with a second request while stepping
        load(8'd4);
        pulse_step();
        cyc(1);
        pulse_step();
        cyc(10);

        // Run stop one cycle after a tick
        load(8'd5);
        run_en = 1'b1;
        cyc(7);
        run_en = 1'b0;
        cyc(12);

        // Reload to zero mid-run
        run_en = 1'b1;
        cyc(7);
        load(8'd0);
        cyc(10);
        run_en = 1'b0;
        cyc(4);

        // Asynchronous reset mid-run, then a full hold
        load(8'd3);
        run_en = 1'b1;
        cyc(8);
        async_reset_check();
        cyc(40);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) run_en = ~run_en;
            step_req = ($urandom_range(0, 7) == 0);
            div_load = ($urandom_range(0, 24) == 0);
            div_in   = DIV_W'($urandom_range(0, 6));
            cyc(1);
            if (i == 1000) begin
                step_req = 1'b0;
                div_load = 1'b0;
                async_reset_check();
            end
        end
        run_en   = 1'b0;
        step_req = 1'b0;
        div_load = 1'b0;
        cyc(20);

        @(negedge clk_in);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got %0d pending expected 0", exp_q.size());
        end
        checks++;
        if (dut_ticks != m_tick_total) begin
            failures++;
            $display("FAIL tick_total got %0d expected %0d", dut_ticks, m_tick_total);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
